// File: rtl/decryption_cfg_master.sv
// decryption_cfg_master: writes cipher config to the register bank, optionally verifies by readback, reports status
module decryption_cfg_master #(
  parameter int addr_width = 8,
  parameter int reg_width = 16,
  parameter int timeout = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_select,
  input  logic [reg_width-1:0]  cfg_caesar_key,
  input  logic [reg_width-1:0]  cfg_scytale_key,
  input  logic [reg_width-1:0]  cfg_zigzag_key,
  input  logic                  cfg_verify,
  output logic [addr_width-1:0] addr,
  output logic                  read,
  output logic                  write,
  output logic [reg_width-1:0]  wdata,
  input  logic [reg_width-1:0]  rdata,
  input  logic                  done,
  input  logic                  error,
  output logic                  busy,
  output logic                  status_valid,
  output logic                  status_ok,
  output logic [1:0]            status_code,
  output logic [addr_width-1:0] fail_addr
);
  localparam logic [2:0] st_idle = 3'd0, st_w_issue = 3'd1, st_w_wait = 3'd2,
                         st_r_issue = 3'd3, st_r_wait = 3'd4, st_report = 3'd5;
  localparam int cw = $clog2(timeout + 1) < 4 ? 4 : $clog2(timeout + 1);
  logic [2:0] state;
  logic [1:0] idx, sel, code, fail_code;
  logic [reg_width-1:0] caesar, scytale, zigzag, key;
  logic [addr_width-1:0] fa;
  logic [cw-1:0] cnt;
  logic verify, ok, waiting, fail;
  always_comb begin
    key = idx == 2'd0 ? caesar : idx == 2'd1 ? scytale : idx == 2'd2 ? zigzag : reg_width'(sel);
    waiting = state == st_w_wait || state == st_r_wait;
    fail_code = !done ? 2'b11 : error ? 2'b01 : 2'b10;
    fail = waiting && (done ? (error || (state == st_r_wait && rdata != key)) : cnt == cw'(timeout - 1));
  end
  assign cfg_ready = state == st_idle && !rst;
  assign busy = state != st_idle;
  assign write = state == st_w_issue;
  assign read = state == st_r_issue;
  assign addr = (!busy || idx == 2'd3) ? '0 : addr_width'({2'b10, idx, 1'b0});
  assign wdata = busy ? key : '0;
  assign status_valid = state == st_report;
  assign status_ok = ok;
  assign status_code = code;
  assign fail_addr = fa;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      idx <= '0;
      cnt <= '0;
      ok <= 1'b0;
      code <= 2'b00;
      fa <= '0;
    end else if (state == st_idle) begin
      if (cfg_valid) begin
        sel <= cfg_select;
        caesar <= cfg_caesar_key;
        scytale <= cfg_scytale_key;
        zigzag <= cfg_zigzag_key;
        verify <= cfg_verify;
        idx <= '0;
        state <= st_w_issue;
      end
    end else if (state == st_w_issue || state == st_r_issue) begin
      cnt <= '0;
      state <= state + 3'd1;
    end else if (state == st_report) begin
      state <= st_idle;
    end else if (fail) begin
      state <= st_report;
      ok <= 1'b0;
      code <= fail_code;
      fa <= addr;
    end else if (done) begin
      idx <= idx + 2'd1;
      if (idx != 2'd3) state <= state - 3'd1;
      else if (state == st_w_wait && verify) state <= st_r_issue;
      else begin
        state <= st_report;
        ok <= 1'b1;
        code <= 2'b00;
        fa <= '0;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_decryption_cfg_master.sv
// tb_decryption_cfg_master: directed scenarios against a cycle-accurate register bank model
module tb_decryption_cfg_master;
  logic clk = 0, rst = 1, bank_rst = 1;
  logic cfg_valid = 0, cfg_verify = 0;
  logic [1:0] cfg_select = 0;
  logic [15:0] cfg_caesar_key = 0, cfg_scytale_key = 0, cfg_zigzag_key = 0;
  logic [7:0] addr, fail_addr;
  logic read, write, busy, status_valid, status_ok, done, error, cfg_ready;
  logic [15:0] wdata, rdata;
  logic [1:0] status_code;
  logic mute = 0, inj_err = 0, corrupt = 0;
  logic [15:0] r_c, r_s, r_z, r_sel;
  int cyc = 0, t0 = 0, errors = 0, checks = 0;
  int nw, nr, nbusy, nsv, both, sv_cyc, rdy_cyc;
  logic [63:0] wsig, wdsig, rsig;
  logic sv_ok;
  logic [1:0] sv_code;
  logic [7:0] sv_fa;

  decryption_cfg_master dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_select(cfg_select), .cfg_caesar_key(cfg_caesar_key),
    .cfg_scytale_key(cfg_scytale_key), .cfg_zigzag_key(cfg_zigzag_key),
    .cfg_verify(cfg_verify), .addr(addr), .read(read), .write(write),
    .wdata(wdata), .rdata(rdata), .done(done), .error(error), .busy(busy),
    .status_valid(status_valid), .status_ok(status_ok),
    .status_code(status_code), .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bank_rst) begin
      done <= 1; error <= 0; rdata <= 0;
      r_c <= 0; r_s <= 0; r_z <= 0; r_sel <= 0;
    end else begin
      done <= (read || write) && !mute;
      error <= (read || write) && (inj_err || !(addr == 0 || addr == 16 || addr == 18 || addr == 20));
      rdata <= !read ? 16'h0 : addr == 16 ? r_c : addr == 18 ? (corrupt ? 16'h0007 : r_s) :
               addr == 20 ? r_z : addr == 0 ? r_sel : 16'h0;
      if (write && !inj_err) begin
        if (addr == 16) r_c <= wdata;
        if (addr == 18) r_s <= wdata;
        if (addr == 20) r_z <= wdata;
        if (addr == 0) r_sel <= wdata;
      end
    end
  end

  always @(negedge clk) begin
    automatic int rel = cyc - t0;
    if (write) begin nw++; wsig = {wsig[47:0], 8'(rel), addr}; wdsig = {wdsig[47:0], wdata}; end
    if (read) begin nr++; rsig = {rsig[47:0], 8'(rel), addr}; end
    if (read && write) both++;
    if (busy && rel > 0) nbusy++;
    if (status_valid) begin nsv++; sv_cyc = rel; sv_ok = status_ok; sv_code = status_code; sv_fa = fail_addr; end
    if (cfg_ready && rel > 0 && rdy_cyc < 0) rdy_cyc = rel;
  end

  task automatic clr();
    t0 = cyc; nw = 0; nr = 0; nbusy = 0; nsv = 0; sv_cyc = -1; rdy_cyc = -1;
    wsig = 0; wdsig = 0; rsig = 0; sv_ok = 0; sv_code = 0; sv_fa = 0;
  endtask

  task automatic issue(input logic [15:0] c, s, z, input logic [1:0] sl, input logic v);
    @(negedge clk);
    cfg_caesar_key = c; cfg_scytale_key = s; cfg_zigzag_key = z; cfg_select = sl; cfg_verify = v;
    cfg_valid = 1;
    clr();
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    run(3);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
    checks++; if ({read, write, busy, status_valid, status_ok} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {read, write, busy, status_valid, status_ok}); end
    checks++; if ({addr, wdata, status_code, fail_addr} !== 34'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {addr, wdata, status_code, fail_addr}); end
    rst = 0; bank_rst = 0;
    run(1);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_done_in_reset();
    clr();
    bank_rst = 1;
    run(3);
    bank_rst = 0;
    run(3);
    checks++; if (nsv !== 0 || nbusy !== 0) begin errors++; $display("FAIL bank_reset_done: got sv=%0d busy=%0d want 0 0", nsv, nbusy); end
  endtask

  task automatic test_write();
    issue(16'h0003, 16'h0004, 16'h0005, 2'd2, 1'b0);
    cfg_caesar_key = 16'h00ff; cfg_select = 2'd3;
    run(14);
    checks++; if (wsig !== 64'h0110_0312_0514_0700 || nw !== 4) begin errors++; $display("FAIL write_seq: got %h n=%0d want 0110031205140700 n=4", wsig, nw); end
    checks++; if (wdsig !== 64'h0003_0004_0005_0002) begin errors++; $display("FAIL write_data: got %h want 0003000400050002", wdsig); end
    checks++; if (nr !== 0 || both !== 0) begin errors++; $display("FAIL write_noread: got reads=%0d both=%0d want 0 0", nr, both); end
    checks++; if (sv_cyc !== 9 || nsv !== 1) begin errors++; $display("FAIL write_status_cycle: got %0d n=%0d want 9 n=1", sv_cyc, nsv); end
    checks++; if ({sv_ok, sv_code, sv_fa} !== 11'b1_00_00000000) begin errors++; $display("FAIL write_status: got ok=%b code=%b fa=%0d want 1 00 0", sv_ok, sv_code, sv_fa); end
    checks++; if (rdy_cyc !== 10 || nbusy !== 9) begin errors++; $display("FAIL write_ready_busy: got ready=%0d busy=%0d want 10 9", rdy_cyc, nbusy); end
    checks++; if ({r_c, r_s, r_z, r_sel} !== 64'h0003_0004_0005_0002) begin errors++; $display("FAIL write_bank: got %h want 0003000400050002", {r_c, r_s, r_z, r_sel}); end
  endtask

  task automatic test_verify();
    issue(16'h0003, 16'h0004, 16'h0005, 2'd2, 1'b1);
    run(22);
    checks++; if (nw !== 4 || wsig !== 64'h0110_0312_0514_0700) begin errors++; $display("FAIL verify_writes: got %h n=%0d want 0110031205140700 n=4", wsig, nw); end
    checks++; if (rsig !== 64'h0910_0b12_0d14_0f00 || nr !== 4) begin errors++; $display("FAIL verify_reads: got %h n=%0d want 09100b120d140f00 n=4", rsig, nr); end
    checks++; if (sv_cyc !== 17 || {sv_ok, sv_code} !== 3'b100) begin errors++; $display("FAIL verify_status: got cyc=%0d ok=%b code=%b want 17 1 00", sv_cyc, sv_ok, sv_code); end
    checks++; if (nbusy !== 17 || both !== 0) begin errors++; $display("FAIL verify_busy: got busy=%0d both=%0d want 17 0", nbusy, both); end
  endtask

  task automatic test_mismatch();
    corrupt = 1;
    issue(16'h0003, 16'h0004, 16'h0005, 2'd2, 1'b1);
    run(22);
    corrupt = 0;
    checks++; if (rsig !== 64'h0910_0b12 || nr !== 2) begin errors++; $display("FAIL mismatch_reads: got %h n=%0d want 09100b12 n=2", rsig, nr); end
    checks++; if (sv_cyc !== 13 || {sv_ok, sv_code, sv_fa} !== {1'b0, 2'b10, 8'd18}) begin errors++; $display("FAIL mismatch_status: got cyc=%0d ok=%b code=%b fa=%0d want 13 0 10 18", sv_cyc, sv_ok, sv_code, sv_fa); end
  endtask

  task automatic test_bus_error();
    inj_err = 1;
    issue(16'h0003, 16'h0004, 16'h0005, 2'd2, 1'b1);
    run(14);
    inj_err = 0;
    checks++; if (nw !== 1 || nr !== 0 || wsig !== 64'h0110) begin errors++; $display("FAIL buserr_strobes: got w=%0d r=%0d sig=%h want 1 0 0110", nw, nr, wsig); end
    checks++; if (sv_cyc !== 3 || {sv_ok, sv_code, sv_fa} !== {1'b0, 2'b01, 8'd16}) begin errors++; $display("FAIL buserr_status: got cyc=%0d ok=%b code=%b fa=%0d want 3 0 01 16", sv_cyc, sv_ok, sv_code, sv_fa); end
    checks++; if ({status_ok, status_code, fail_addr} !== {1'b0, 2'b01, 8'd16}) begin errors++; $display("FAIL buserr_hold: got ok=%b code=%b fa=%0d want 0 01 16", status_ok, status_code, fail_addr); end
  endtask

  task automatic test_timeout();
    mute = 1;
    issue(16'h0003, 16'h0004, 16'h0005, 2'd2, 1'b0);
    run(24);
    mute = 0;
    checks++; if (nw !== 1 || nr !== 0) begin errors++; $display("FAIL timeout_strobes: got w=%0d r=%0d want 1 0", nw, nr); end
    checks++; if (sv_cyc !== 17 || {sv_ok, sv_code, sv_fa} !== {1'b0, 2'b11, 8'd16}) begin errors++; $display("FAIL timeout_status: got cyc=%0d ok=%b code=%b fa=%0d want 17 0 11 16", sv_cyc, sv_ok, sv_code, sv_fa); end
  endtask

  task automatic test_reset_mid();
    issue(16'h0003, 16'h0004, 16'h0005, 2'd2, 1'b1);
    run(3);
    rst = 1;
    run(1);
    checks++; if ({read, write, busy, cfg_ready, status_valid} !== 5'b0 || addr !== 8'd0) begin errors++; $display("FAIL midrst_outputs: got %b addr=%0d want 00000 0", {read, write, busy, cfg_ready, status_valid}, addr); end
    rst = 0;
    run(1);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", cfg_ready); end
    run(20);
    checks++; if (nsv !== 0) begin errors++; $display("FAIL midrst_nostatus: got %0d want 0", nsv); end
    issue(16'h0011, 16'h0022, 16'h0033, 2'd1, 1'b1);
    run(22);
    checks++; if (sv_cyc !== 17 || {sv_ok, sv_code} !== 3'b100) begin errors++; $display("FAIL midrst_recover: got cyc=%0d ok=%b code=%b want 17 1 00", sv_cyc, sv_ok, sv_code); end
    checks++; if ({r_c, r_s, r_z, r_sel} !== 64'h0011_0022_0033_0001) begin errors++; $display("FAIL midrst_bank: got %h want 0011002200330001", {r_c, r_s, r_z, r_sel}); end
  endtask

  initial begin
    both = 0;
    clr();
    test_reset();
    test_done_in_reset();
    test_write();
    test_verify();
    test_mismatch();
    test_bus_error();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
